// File: rtl/uart_rx_engine.sv
// uart_rx_engine
// UART receive controller: synchronizes the serial line, validates the start
// bit at mid-bit, samples 7/8 data bits plus optional parity and one stop bit,
// and presents the byte to the host with a ready/read handshake.
//
// Ports
//   clk      system clock
//   reset    asynchronous active-high reset
//   rx       serial line (asynchronous, idle high)
//   baud_k   clocks per bit time (>= 4), captured at frame start
//   eight    1 = 8 data bits, 0 = 7 data bits (captured at frame start)
//   pen      parity enable (captured at frame start)
//   ohel     parity sense, 1 = odd, 0 = even (captured at frame start)
//   read     one-cycle pulse, host consumes rx_data
//   rx_data  received byte, bit 7 = 0 in 7-bit mode
//   rx_rdy   frame available
//   perr     parity error of the last frame
//   ferr     framing error (stop bit sampled low) of the last frame
//   ovf      frame completed while rx_rdy was still set
module uart_rx_engine #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [CNT_W-1:0] baud_k,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             read,
  output logic [7:0]       rx_data,
  output logic             rx_rdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             rxs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shift_q;
  logic [CNT_W-1:0] baud_q;
  logic             eight_q;
  logic             pen_q;
  logic             ohel_q;
  logic [7:0]       rx_data_q;
  logic             rx_rdy_q;
  logic             perr_q;
  logic             ferr_q;
  logic             ovf_q;

  logic [CNT_W-1:0] tgt_d;
  logic             btu_d;
  logic [3:0]       nbits_d;
  logic [9:0]       frame_d;
  logic [7:0]       data_d;
  logic             par_bit_d;
  logic             stop_bit_d;
  logic             perr_d;

  // Start bit is checked half a bit time in; data bits one full bit apart,
  // so every later sample lands mid-bit.
  always_comb begin
    tgt_d = baud_q - CNT_W'(1);
    if (state_q == START) tgt_d = (baud_q >> 1) - CNT_W'(1);
    btu_d = ((state_q == START) || (state_q == DATA)) && (cnt_q == tgt_d);
  end

  // Bits enter at [9] and move right, so after n samples the first data bit
  // sits at [10-n]; shifting by 10-n puts it at [0] with the stop bit at [n-1].
  always_comb begin
    nbits_d    = (eight_q ? 4'd8 : 4'd7) + {3'b000, pen_q} + 4'd1;
    frame_d    = shift_q >> (4'd10 - nbits_d);
    data_d     = eight_q ? frame_d[7:0] : {1'b0, frame_d[6:0]};
    par_bit_d  = eight_q ? frame_d[8] : frame_d[7];
    stop_bit_d = frame_d[nbits_d - 4'd1];
    perr_d     = pen_q & (^data_d ^ par_bit_d ^ ohel_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      baud_q    <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      rx_data_q <= '0;
      rx_rdy_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;

      if (read && rx_rdy_q) begin
        rx_rdy_q <= 1'b0;
        ovf_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= START;
            baud_q  <= baud_k;
            eight_q <= eight;
            pen_q   <= pen;
            ohel_q  <= ohel;
          end
        end
        START: begin
          if (btu_d) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= rxs_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (btu_d) begin
            cnt_q     <= '0;
            shift_q   <= {rxs_q, shift_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if ((bit_cnt_q + 4'd1) == nbits_d) state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          // These assignments come after the read clear above, so a read in
          // this cycle loses to the new frame.
          state_q   <= IDLE;
          cnt_q     <= '0;
          rx_data_q <= data_d;
          ferr_q    <= ~stop_bit_d;
          perr_q    <= perr_d;
          ovf_q     <= rx_rdy_q & ~read;
          rx_rdy_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rx_rdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: drives serial frames at 16 clocks per bit
// and compares the host-side outputs against hand-computed values.
module tb_uart_rx_engine;

  localparam int CNT_W = 19;
  localparam int BIT   = 16;

  logic             clk;
  logic             reset;
  logic             rx;
  logic [CNT_W-1:0] baud_k;
  logic             eight;
  logic             pen;
  logic             ohel;
  logic             read;
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             perr;
  logic             ferr;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_engine #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .read    (read),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .perr    (perr),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("read_clr_rdy", 32'(rx_rdy), 32'd0);
    check("read_clr_ovf", 32'(ovf), 32'd0);
  endtask

  // Drives one frame, changing rx on negedges. Offsets (rd_at, chg_at, rst_at)
  // count negedges from the start-bit edge; -1 disables. With the two-flop
  // synchronizer and half-bit start check, the stop bit is sampled at offset
  // 16n+10 after which DONE occupies the cycle seen at offset 16n+11.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit lat, input int rd_at, input int chg_at,
                            input int rst_at);
    int nd;
    int n;
    int idx;
    logic b;
    nd = eight ? 8 : 7;
    n  = nd + (pen ? 1 : 0) + 1;
    for (int j = 0; j <= n; j++) begin
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        idx = j * BIT + c;
        if (c == 0) begin
          if (j == 0)                   b = 1'b0;
          else if (j <= nd)             b = d[j-1];
          else if (pen && j == nd + 1)  b = par;
          else                          b = stop;
          rx = b;
        end
        read = (idx == rd_at);
        if (idx == chg_at) baud_k = 19'd32;
        if (lat && idx == BIT * n + 11) check("lat_pre", 32'(rx_rdy), 32'd0);
        if (lat && idx == BIT * n + 12) check("lat_rdy", 32'(rx_rdy), 32'd1);
        if (idx == rst_at) begin
          #2 reset = 1'b1;
          #1;
          check("rst_async_rdy",  32'(rx_rdy), 32'd0);
          check("rst_async_data", 32'(rx_data), 32'd0);
          check("rst_async_ovf",  32'(ovf), 32'd0);
          check("rst_async_ferr", 32'(ferr), 32'd0);
          check("rst_async_perr", 32'(perr), 32'd0);
        end
      end
    end
    @(negedge clk);
    rx    = 1'b1;
    read  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    baud_k = 19'd16;
    eight  = 1'b1;
    pen    = 1'b0;
    ohel   = 1'b0;
    read   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy",  32'(rx_rdy), 32'd0);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_perr", 32'(perr), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_ovf",  32'(ovf), 32'd0);
    reset = 1'b0;
    idle(10);

    // Nominal 8N1, 0xA5, with exact latency check
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, -1, -1);
    check("8n1_data", 32'(rx_data), 32'hA5);
    check("8n1_rdy",  32'(rx_rdy), 32'd1);
    check("8n1_perr", 32'(perr), 32'd0);
    check("8n1_ferr", 32'(ferr), 32'd0);
    check("8n1_ovf",  32'(ovf), 32'd0);
    do_read();
    idle(8);

    // 7-bit even parity
    eight = 1'b0;
    pen   = 1'b1;
    ohel  = 1'b0;
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    check("7e_data", 32'(rx_data), 32'h41);
    check("7e_perr_ok", 32'(perr), 32'd0);
    do_read();
    idle(8);
    send_frame(8'h41, 1'b1, 1'b1, 1'b0, -1, -1, -1);
    check("7e_perr_bad", 32'(perr), 32'd1);
    check("7e_data2", 32'(rx_data), 32'h41);
    do_read();
    idle(8);
    ohel = 1'b1;
    send_frame(8'hC1, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    check("7o_perr_bad", 32'(perr), 32'd1);
    check("7o_data_b7", 32'(rx_data), 32'h41);
    do_read();
    idle(8);

    // False start, then framing error
    eight = 1'b1;
    pen   = 1'b0;
    ohel  = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    idle(40);
    check("false_start_rdy", 32'(rx_rdy), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, -1, -1);
    idle(40);
    check("ferr_flag", 32'(ferr), 32'd1);
    check("ferr_data", 32'(rx_data), 32'h3C);
    check("ferr_rdy",  32'(rx_rdy), 32'd1);
    check("ferr_perr", 32'(perr), 32'd0);
    do_read();
    idle(8);

    // Overrun
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    idle(8);
    check("ovr_first_ovf", 32'(ovf), 32'd0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_ovf",  32'(ovf), 32'd1);
    check("ovr_ferr", 32'(ferr), 32'd0);
    do_read();
    idle(8);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    check("pre_coinc_rdy", 32'(rx_rdy), 32'd1);
    idle(8);
    // read lands in the DONE cycle of this frame (offset 16*9+11)
    send_frame(8'h44, 1'b0, 1'b1, 1'b0, BIT * 9 + 11, -1, -1);
    check("coinc_rdy",  32'(rx_rdy), 32'd1);
    check("coinc_ovf",  32'(ovf), 32'd0);
    check("coinc_data", 32'(rx_data), 32'h44);
    do_read();
    idle(8);

    // Reset midway through data bits, with a frame pending
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, -1, -1, -1);
    check("pre_rst_rdy", 32'(rx_rdy), 32'd1);
    idle(8);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, -1, -1, BIT * 4 + 3);
    idle(40);
    check("post_rst_rdy", 32'(rx_rdy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1, -1, -1);
    check("post_rst_data", 32'(rx_data), 32'h5A);
    check("post_rst_ferr", 32'(ferr), 32'd0);
    do_read();
    idle(8);

    // baud_k change mid-frame has no effect on the current frame
    send_frame(8'h96, 1'b0, 1'b1, 1'b0, -1, 40, -1);
    check("baud_chg_data", 32'(rx_data), 32'h96);
    check("baud_chg_ferr", 32'(ferr), 32'd0);
    check("baud_chg_rdy",  32'(rx_rdy), 32'd1);
    baud_k = 19'd16;
    do_read();
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
